bit32_seq_mult: RTL and testbench
=================================

BIT32_SEQ_MULT -- requirements
Module: bit32_seq_mult

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 32, operand width
- CNT_W, 6, iteration counter width
REQ-002 The module SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- in1  input  32  multiplicand, unsigned
- in2  input  32  multiplier, unsigned
- busy  output  1  high while iterating (RUN)
- done  output  1  one-cycle pulse; product valid
- product  output  64  unsigned in1*in2

Function
REQ-004 The block SHALL compute a 64-bit unsigned product by shift-and-add, one iteration per clock.
REQ-005 The FSM SHALL have three states:
- IDLE: waits for start.
- RUN: performs 32 iterations.
- DONE: lasts exactly one cycle, then returns to IDLE.
REQ-006 IDLE with start=1 at an edge SHALL do all of the following at that edge:
- capture in1 into the multiplicand register;
- load product = {32'h0, in2};
- clear the counter;
- enter RUN.
REQ-007 Each RUN edge SHALL perform one iteration:
- If product[0]=1: sum33 = {carry, product[63:32] + multiplicand}; else sum33 = {1'b0, product[63:32]}.
- Update product = {sum33, product[31:1]}, i.e. a right shift by one bit of the 65-bit value formed by the adder carry and the updated upper half.
- Increment the counter.
REQ-008 The adder carry-out SHALL be retained as the MSB shifted into product[63]; no carry SHALL be lost.
REQ-009 On the RUN edge that performs iteration 32 (counter = 31), the FSM SHALL enter DONE.
REQ-010 done SHALL be 1 only in DONE, exactly 32 clock edges after the start-accepting edge.
REQ-011 busy SHALL be 1 only in RUN; it SHALL be 0 in IDLE and DONE.
REQ-012 start SHALL be ignored in RUN and DONE, with no effect on the operation in progress or its result.
REQ-013 A start in the cycle immediately after DONE (back in IDLE) SHALL be accepted normally.
REQ-014 in1/in2 changes after the start-accepting edge SHALL NOT affect the result.
REQ-015 product SHALL hold the final value from DONE until the next accepted start; in RUN it shows partial results and is undefined as a result.
REQ-016 Boundary results:
- in1=0 or in2=0 SHALL yield product=0.
- 32'hFFFFFFFF*32'hFFFFFFFF SHALL yield 64'hFFFFFFFE_00000001.

Reset
REQ-017 When rst=1 at a clock edge, the block SHALL enter IDLE and clear the following (rst overrides start):
- product=0
- multiplicand=0
- counter=0
- busy=0
- done=0
REQ-018 A reset asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-019 Reset SHALL NOT be asynchronous; outputs change only on clk edges.

Structure
REQ-020 A shared header SHALL define:
- WIDTH and the iteration count (32);
- the state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10.
REQ-021 The add step SHALL instantiate the existing combinational 32-bit adder bit32_fadder (out, carry, cin, in1, in2) with cin tied to 0.
REQ-022 The FSM, counter and shift register SHALL live in bit32_seq_mult; no other sub-modules.

Verification
REQ-023 Each scenario SHALL be checked by the bench:
- rst=1 for 2 cycles -> product=0, busy=0, done=0.
- in1=3, in2=5, start pulse -> busy high for 32 cycles; done pulses once, 32 edges after start; product=64'h0F; product holds afterwards.
- in1=32'h80000000, in2=2 -> product=64'h00000001_00000000 (carry path).
- in1=in2=32'hFFFFFFFF -> product=64'hFFFFFFFE_00000001.
- in1=7, in2=9 started; at cycle 10 of RUN apply start with in1=in2=1 and change in1/in2 -> product=64'd63 (start and operand changes ignored).
- start with in1=100, in2=100; rst at cycle 15 of RUN -> IDLE, product=0, no done pulse; next start with in1=0, in2=123 -> product=0.

Source files
------------

// File: rtl/bit32_seq_mult_pkg.sv
// bit32_seq_mult_pkg: shared widths, iteration count and FSM state encoding
package bit32_seq_mult_pkg;
  localparam int DATA_W = 32;
  localparam int ITERS = 32;
  localparam int CNT_BITS = 6;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/bit32_fadder.sv
// bit32_fadder: combinational 32-bit adder with carry-in and carry-out
module bit32_fadder
  import bit32_seq_mult_pkg::*;
(
  output logic [DATA_W-1:0] out,
  output logic              carry,
  input  logic              cin,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2
);
  assign {carry, out} = {1'b0, in1} + {1'b0, in2} + {{DATA_W{1'b0}}, cin};
endmodule

// File: rtl/bit32_seq_mult.sv
// bit32_seq_mult: 32x32 unsigned shift-and-add multiplier, one iteration per clock
module bit32_seq_mult
  import bit32_seq_mult_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = CNT_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;
  logic [WIDTH:0]     w_sum33;
  logic               w_accept;
  bit32_fadder u_add (
    .out  (w_sum),
    .carry(w_carry),
    .cin  (1'b0),
    .in1  (r_prod[2*WIDTH-1:WIDTH]),
    .in2  (r_mcand)
  );
  assign w_accept = (r_state == IDLE) && start;
  // carry is kept as bit 32 so the right shift moves it into product[63]
  assign w_sum33 = r_prod[0] ? {w_carry, w_sum} : {1'b0, r_prod[2*WIDTH-1:WIDTH]};
  always_comb begin
    w_next = r_state;
    w_next = w_accept ? RUN
           : (r_state == RUN && r_cnt == CNT_W'(ITERS - 1)) ? DONE
           : (r_state == DONE) ? IDLE
           : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mcand <= in1;
        r_prod  <= {{WIDTH{1'b0}}, in2};
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_prod <= {w_sum33, r_prod[WIDTH-1:1]};
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end
  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign product = r_prod;
endmodule

// File: tb/tb_bit32_seq_mult.sv
// tb_bit32_seq_mult: directed and random checks of bit32_seq_mult against a plain-arithmetic model
module tb_bit32_seq_mult;
  logic        clk = 1'b0;
  logic        rst, start, busy, done;
  logic [31:0] in1, in2;
  logic [63:0] product;
  int total = 0;
  int bad = 0;

  bit32_seq_mult dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in1    (in1),
    .in2    (in2),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    return {32'h0, a} * {32'h0, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // accepts a start, watches 32 RUN cycles, checks the done pulse and the held result;
  // at RUN cycle poke a spurious start with operands 1/1 is applied
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int poke);
    logic [63:0] e;
    e = model(a, b);
    in1 = a;
    in2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in1 = $urandom;
    in2 = $urandom;
    for (int c = 0; c < 32; c++) begin
      chk("busy_run", {63'h0, busy}, 64'h1);
      chk("done_run", {63'h0, done}, 64'h0);
      if (c == poke) begin
        start = 1'b1;
        in1 = 32'h1;
        in2 = 32'h1;
      end else start = 1'b0;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("done_pulse", {63'h0, done}, 64'h1);
    chk("busy_done", {63'h0, busy}, 64'h0);
    chk("product", product, e);
    @(posedge clk);
    #1;
    chk("done_after", {63'h0, done}, 64'h0);
    chk("busy_idle", {63'h0, busy}, 64'h0);
    chk("product_hold", product, e);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in1 = '0;
    in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_product", product, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_mul(32'd3, 32'd5, -1);
    chk("const_3x5", product, 64'h0F);
    run_mul(32'h8000_0000, 32'd2, -1);
    chk("const_carry", product, 64'h0000_0001_0000_0000);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("const_max", product, 64'hFFFF_FFFE_0000_0001);
    run_mul(32'd7, 32'd9, 10);
    chk("const_ignore_start", product, 64'd63);
    run_mul(32'h0, 32'hDEAD_BEEF, -1);
    run_mul(32'h1234_5678, 32'h0, -1);
    for (int i = 0; i < 8; i++) run_mul($urandom, $urandom, (i % 2 == 0) ? int'($urandom_range(0, 31)) : -1);
    in1 = 32'd100;
    in2 = 32'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_product", product, 64'h0);
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_done", {63'h0, done}, 64'h0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", {62'h0, busy, done}, 64'h0);
    end
    run_mul(32'd0, 32'd123, -1);
    chk("const_zero", product, 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
